// File: rtl/wt_mem_arbiter.sv
// wt_mem_arbiter
//   Memory-side arbiter for the write-through cache subsystem. NumPorts cache
//   clients share one adapter port. Each accepted client transaction is given
//   a downstream ID equal to the index of a free entry in a MaxTx-deep
//   transaction table. The table remembers {port, client tid}. Returns are
//   steered back to the owning client with the original tid restored.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   stall_i                 blocks new grants (a locked request still completes)
//   busy_o                  any entry valid or a request on the adapter port
//   err_o                   sticky: return seen for an unallocated downstream ID
//   outstanding_o           number of valid table entries
//   req_i/ack_o             per-client request valid / one-hot accept
//   req_data_i/req_tid_i    per-client payload and transaction ID (packed)
//   rtrn_vld_o              per-client one-hot return strobe
//   rtrn_data_o/rtrn_tid_o  return payload (broadcast) and restored client ID
//   mem_req_o/mem_ack_i     adapter request handshake
//   mem_data_o/mem_tid_o    selected payload and downstream ID (table index)
//   mem_rtrn_*_i            adapter return beat (one per transaction)
module wt_mem_arbiter #(
  parameter int NumPorts  = 2,
  parameter int ReqWidth  = 128,
  parameter int RtrnWidth = 160,
  parameter int TidWidth  = 2,
  parameter int MaxTx     = 8,
  parameter int FixedPrio = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            stall_i,
  output logic                            busy_o,
  output logic                            err_o,
  output logic [$clog2(MaxTx+1)-1:0]      outstanding_o,
  input  logic [NumPorts-1:0]             req_i,
  output logic [NumPorts-1:0]             ack_o,
  input  logic [NumPorts*ReqWidth-1:0]    req_data_i,
  input  logic [NumPorts*TidWidth-1:0]    req_tid_i,
  output logic [NumPorts-1:0]             rtrn_vld_o,
  output logic [RtrnWidth-1:0]            rtrn_data_o,
  output logic [TidWidth-1:0]             rtrn_tid_o,
  output logic                            mem_req_o,
  input  logic                            mem_ack_i,
  output logic [ReqWidth-1:0]             mem_data_o,
  output logic [$clog2(MaxTx)-1:0]        mem_tid_o,
  input  logic                            mem_rtrn_vld_i,
  input  logic [$clog2(MaxTx)-1:0]        mem_rtrn_tid_i,
  input  logic [RtrnWidth-1:0]            mem_rtrn_data_i
);

  localparam int IdxW  = $clog2(MaxTx);
  localparam int CntW  = $clog2(MaxTx + 1);
  localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [PortW-1:0]      rr_q, rr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;

  // transaction table
  logic [MaxTx-1:0]      vld_q;
  logic [PortW-1:0]      port_q [MaxTx];
  logic [TidWidth-1:0]   tid_q  [MaxTx];

  // frozen grant while the adapter holds off the handshake
  logic [PortW-1:0]      sel_q;
  logic [IdxW-1:0]       ent_q;

  logic [NumPorts-1:0]   rtrn_vld_q;
  logic [RtrnWidth-1:0]  rtrn_data_q;
  logic [TidWidth-1:0]   rtrn_tid_q;

  logic                  free_en;
  logic [MaxTx-1:0]      free_mask;
  logic                  any_free;
  logic [IdxW-1:0]       alloc_ent;
  logic                  arb_found;
  logic [PortW-1:0]      arb_sel;
  logic                  grant_vld;
  logic [PortW-1:0]      cur_sel;
  logic [IdxW-1:0]       cur_ent;
  logic                  accept;
  logic [NumPorts-1:0]   rtrn_oh;

  // Return decode. An entry being freed this cycle is masked out of
  // allocation so one index is never both released and handed out.
  assign free_en = mem_rtrn_vld_i & vld_q[mem_rtrn_tid_i];

  always_comb begin
    for (int i = 0; i < MaxTx; i++) begin
      free_mask[i] = free_en && (mem_rtrn_tid_i == IdxW'(i));
    end
  end

  // Lowest-index free entry: scanning downward lets the lowest hit win.
  always_comb begin
    any_free  = 1'b0;
    alloc_ent = '0;
    for (int i = MaxTx - 1; i >= 0; i--) begin
      if (!vld_q[i] && !free_mask[i]) begin
        any_free  = 1'b1;
        alloc_ent = IdxW'(i);
      end
    end
  end

  // Port selection: scan in priority order from last to first so the
  // highest-priority requester is the final assignment.
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_sel   = '0;
    idx       = 0;
    for (int j = NumPorts - 1; j >= 0; j--) begin
      idx = (FixedPrio != 0) ? j : ((int'(rr_q) + j) % NumPorts);
      if (req_i[PortW'(idx)]) begin
        arb_found = 1'b1;
        arb_sel   = PortW'(idx);
      end
    end
  end

  assign grant_vld = !stall_i && any_free && arb_found;

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld && !mem_ack_i) state_d = LOCKED;
      LOCKED:  if (mem_ack_i)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Reset gates the combinational request so nothing is
  // offered to the adapter while rst_i is high.
  always_comb begin
    cur_sel   = (state_q == LOCKED) ? sel_q : arb_sel;
    cur_ent   = (state_q == LOCKED) ? ent_q : alloc_ent;
    mem_req_o = !rst_i && ((state_q == LOCKED) || grant_vld);
    ack_o     = '0;
    if (mem_req_o && mem_ack_i) ack_o[cur_sel] = 1'b1;
  end

  assign accept     = mem_req_o & mem_ack_i;
  assign mem_tid_o  = cur_ent;
  assign mem_data_o = req_data_i[int'(cur_sel)*ReqWidth +: ReqWidth];

  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && grant_vld && !mem_ack_i) begin
      sel_q <= arb_sel;
      ent_q <= alloc_ent;
    end
  end

  // control next-state
  always_comb begin
    rr_d  = rr_q;
    if (accept) begin
      rr_d = (int'(cur_sel) == NumPorts - 1) ? '0 : cur_sel + PortW'(1);
    end
    // freed and allocated indices are disjoint, so the count cannot wrap
    cnt_d = cnt_q + {{(CntW-1){1'b0}}, accept} - {{(CntW-1){1'b0}}, free_en};
    err_d = err_q | (mem_rtrn_vld_i & ~vld_q[mem_rtrn_tid_i]);
  end

  always_comb begin
    rtrn_oh = '0;
    if (free_en) rtrn_oh[port_q[mem_rtrn_tid_i]] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      vld_q       <= '0;
      rtrn_vld_q  <= '0;
      rtrn_data_q <= '0;
      rtrn_tid_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rtrn_vld_q <= rtrn_oh;
      for (int i = 0; i < MaxTx; i++) begin
        if (accept && (cur_ent == IdxW'(i))) vld_q[i] <= 1'b1;
        else if (free_mask[i])               vld_q[i] <= 1'b0;
      end
      if (free_en) begin
        rtrn_data_q <= mem_rtrn_data_i;
        rtrn_tid_q  <= tid_q[mem_rtrn_tid_i];
      end
    end
  end

  // table payload, qualified by vld_q
  always_ff @(posedge clk_i) begin
    if (accept) begin
      port_q[cur_ent] <= cur_sel;
      tid_q[cur_ent]  <= req_tid_i[int'(cur_sel)*TidWidth +: TidWidth];
    end
  end

  assign rtrn_vld_o    = rtrn_vld_q;
  assign rtrn_data_o   = rtrn_data_q;
  assign rtrn_tid_o    = rtrn_tid_q;
  assign err_o         = err_q;
  assign outstanding_o = cnt_q;
  assign busy_o        = (|vld_q) | mem_req_o;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
module tb_wt_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         stall_i;
  logic [1:0]   req_i;
  logic [255:0] req_data_i;
  logic [3:0]   req_tid_i;
  logic         mem_ack_i;
  logic         mem_rtrn_vld_i;
  logic [2:0]   mem_rtrn_tid_i;
  logic [159:0] mem_rtrn_data_i;

  logic         busy_o, err_o, mem_req_o;
  logic [3:0]   outstanding_o;
  logic [1:0]   ack_o, rtrn_vld_o;
  logic [159:0] rtrn_data_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] mem_data_o;
  logic [2:0]   mem_tid_o;

  logic         fp_busy_o, fp_err_o, fp_mem_req_o;
  logic [3:0]   fp_outstanding_o;
  logic [1:0]   fp_ack_o, fp_rtrn_vld_o;
  logic [159:0] fp_rtrn_data_o;
  logic [1:0]   fp_rtrn_tid_o;
  logic [127:0] fp_mem_data_o;
  logic [2:0]   fp_mem_tid_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wt_mem_arbiter #(.FixedPrio(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .busy_o(busy_o),
    .err_o(err_o), .outstanding_o(outstanding_o), .req_i(req_i),
    .ack_o(ack_o), .req_data_i(req_data_i), .req_tid_i(req_tid_i),
    .rtrn_vld_o(rtrn_vld_o), .rtrn_data_o(rtrn_data_o),
    .rtrn_tid_o(rtrn_tid_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_tid_o(mem_tid_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_tid_i(mem_rtrn_tid_i),
    .mem_rtrn_data_i(mem_rtrn_data_i)
  );

  wt_mem_arbiter #(.FixedPrio(1)) dut_fp (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .busy_o(fp_busy_o),
    .err_o(fp_err_o), .outstanding_o(fp_outstanding_o), .req_i(req_i),
    .ack_o(fp_ack_o), .req_data_i(req_data_i), .req_tid_i(req_tid_i),
    .rtrn_vld_o(fp_rtrn_vld_o), .rtrn_data_o(fp_rtrn_data_o),
    .rtrn_tid_o(fp_rtrn_tid_o), .mem_req_o(fp_mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_data_o(fp_mem_data_o), .mem_tid_o(fp_mem_tid_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_tid_i(mem_rtrn_tid_i),
    .mem_rtrn_data_i(mem_rtrn_data_i)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; req_i = 2'b00; req_data_i = '0; req_tid_i = '0;
    mem_ack_i = 1'b0; mem_rtrn_vld_i = 1'b0; mem_rtrn_tid_i = '0; mem_rtrn_data_i = '0;
    step(); step();
    rst_i = 1'b0;
    step();
    chk("idle_busy", busy_o, 0);
    chk("idle_err", err_o, 0);
    chk("idle_outstanding", outstanding_o, 0);
    chk("idle_mem_req", mem_req_o, 0);
    chk("idle_rtrn_vld", rtrn_vld_o, 0);

    // ID remap: port 1 tid 3 becomes downstream ID 0
    req_i = 2'b10; req_tid_i = {2'd3, 2'd0}; mem_ack_i = 1'b1;
    req_data_i = {128'h1234, 128'h0};
    #1;
    chk("remap_ack", ack_o, 2'b10);
    chk("remap_mem_tid", mem_tid_o, 0);
    chk("remap_mem_data", mem_data_o, 128'h1234);
    step();
    chk("remap_outstanding", outstanding_o, 1);
    req_i = 2'b00;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 3'd0; mem_rtrn_data_i = 160'hABCD;
    step();
    mem_rtrn_vld_i = 1'b0;
    chk("remap_rtrn_vld", rtrn_vld_o, 2'b10);
    chk("remap_rtrn_tid", rtrn_tid_o, 3);
    chk("remap_rtrn_data", rtrn_data_o, 160'hABCD);
    chk("remap_outstanding_drop", outstanding_o, 0);
    step();
    chk("remap_rtrn_vld_clear", rtrn_vld_o, 0);

    // Round-robin fill: grants alternate, IDs ascend, table fills to 8
    req_i = 2'b11; req_tid_i = {2'd2, 2'd1};
    req_data_i = {128'hB1, 128'hA0};
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ack", ack_o, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_mem_tid", mem_tid_o, k);
      chk("rr_mem_data", mem_data_o, (k % 2 == 1) ? 128'hB1 : 128'hA0);
      chk("fp_ack", fp_ack_o, 2'b01);
      chk("fp_mem_tid", fp_mem_tid_o, k);
      step();
      chk("rr_outstanding", outstanding_o, k + 1);
    end

    // Full: requests pending but nothing offered
    #1;
    chk("full_mem_req", mem_req_o, 0);
    chk("full_ack", ack_o, 0);
    chk("full_busy", busy_o, 1);

    // Free entry 5 while a request waits: it is not reusable this cycle
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 3'd5; mem_rtrn_data_i = 160'h55;
    #1;
    chk("free_same_cycle_mem_req", mem_req_o, 0);
    step();
    mem_rtrn_vld_i = 1'b0;
    chk("free_rtrn_vld", rtrn_vld_o, 2'b10);
    chk("free_rtrn_tid", rtrn_tid_o, 2);
    chk("free_outstanding", outstanding_o, 7);
    chk("fp_free_rtrn_vld", fp_rtrn_vld_o, 2'b01);
    #1;
    chk("regrant_mem_req", mem_req_o, 1);
    chk("regrant_mem_tid", mem_tid_o, 5);
    chk("regrant_ack", ack_o, 2'b01);
    step();
    chk("regrant_outstanding", outstanding_o, 8);

    // Release entry 2 (port 0, tid 1)
    req_i = 2'b00;
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 3'd2; mem_rtrn_data_i = 160'h22;
    step();
    mem_rtrn_vld_i = 1'b0;
    chk("rel2_rtrn_vld", rtrn_vld_o, 2'b01);
    chk("rel2_rtrn_tid", rtrn_tid_o, 1);
    chk("rel2_outstanding", outstanding_o, 7);

    // Handshake hold with stall rising in the second wait cycle
    req_i = 2'b10; req_tid_i = {2'd2, 2'd1}; req_data_i = {128'h222, 128'hA0};
    mem_ack_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) stall_i = 1'b1;
      #1;
      chk("hold_mem_req", mem_req_o, 1);
      chk("hold_mem_tid", mem_tid_o, 2);
      chk("hold_mem_data", mem_data_o, 128'h222);
      chk("hold_ack", ack_o, 0);
      step();
    end
    mem_ack_i = 1'b1;
    #1;
    chk("hold_ack_pulse", ack_o, 2'b10);
    chk("hold_ack_mem_tid", mem_tid_o, 2);
    step();
    chk("hold_outstanding", outstanding_o, 8);
    chk("hold_ack_gone", ack_o, 0);
    chk("hold_mem_req_gone", mem_req_o, 0);
    req_i = 2'b00; stall_i = 1'b0;

    // Error: free entry 7, then return to it again
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 3'd7; mem_rtrn_data_i = 160'h77;
    step();
    chk("rel7_rtrn_vld", rtrn_vld_o, 2'b10);
    chk("rel7_err", err_o, 0);
    step();
    mem_rtrn_vld_i = 1'b0;
    chk("err_rtrn_vld", rtrn_vld_o, 0);
    chk("err_set", err_o, 1);
    chk("err_outstanding", outstanding_o, 7);
    step(); step();
    chk("err_sticky", err_o, 1);

    // Asynchronous reset mid-cycle, with requests pending
    req_i = 2'b11;
    #3;
    rst_i = 1'b1;
    #1;
    chk("arst_err", err_o, 0);
    chk("arst_outstanding", outstanding_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_mem_req", mem_req_o, 0);
    chk("arst_ack", ack_o, 0);
    chk("arst_rtrn_vld", rtrn_vld_o, 0);
    chk("arst_rtrn_tid", rtrn_tid_o, 0);
    req_i = 2'b00;
    step();
    rst_i = 1'b0;
    step();
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_err", err_o, 0);

    // Late return after reset hits an invalid entry
    mem_rtrn_vld_i = 1'b1; mem_rtrn_tid_i = 3'd3;
    step();
    mem_rtrn_vld_i = 1'b0;
    chk("late_rtrn_vld", rtrn_vld_o, 0);
    chk("late_err", err_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wt_mem_arbiter.md
Name: wt_mem_arbiter

Overview:
Parametrised memory-side arbiter for the write-through cache subsystem. It generalises the fixed two-client (I$ ID 0, D$ ID 1) plumbing to NumPorts cache clients sharing one memory adapter port. It arbitrates requests and remaps each client transaction ID to a unique downstream ID drawn from a tracked pool of MaxTx entries. Returns are routed back to the owning client with the original ID restored. It sits between the L1 caches and the AXI/L15 adapter.

Parameters:
NumPorts, 2, number of cache clients (>=1).
ReqWidth, 128, opaque request payload bits (address, size, type, write data).
RtrnWidth, 160, opaque return payload bits.
TidWidth, 2, client transaction ID width.
MaxTx, 8, downstream outstanding-transaction table depth (>=2, power of two).
FixedPrio, 0, 0 = round-robin arbitration, 1 = fixed priority with port 0 highest.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
stall_i  in  1  blocks new grants; pending handshake still completes
busy_o  out  1  any table entry valid or mem_req_o high
err_o  out  1  sticky: return received for an unallocated downstream ID
outstanding_o  out  $clog2(MaxTx+1)  number of valid table entries
req_i  in  NumPorts  per-client request valid
ack_o  out  NumPorts  per-client accept, one-hot or zero
req_data_i  in  NumPorts*ReqWidth  per-client payload
req_tid_i  in  NumPorts*TidWidth  per-client transaction ID
rtrn_vld_o  out  NumPorts  per-client return strobe, one-hot or zero
rtrn_data_o  out  RtrnWidth  return payload, broadcast to all clients
rtrn_tid_o  out  TidWidth  restored client ID
mem_req_o  out  1  request to adapter
mem_ack_i  in  1  adapter accept
mem_data_o  out  ReqWidth  selected payload
mem_tid_o  out  $clog2(MaxTx)  downstream ID, equal to the table index
mem_rtrn_vld_i  in  1  return valid, one beat per transaction
mem_rtrn_tid_i  in  $clog2(MaxTx)  downstream ID of the return
mem_rtrn_data_i  in  RtrnWidth  return payload

Behaviour:
- Reset (async, rst_i=1): all table entries invalid. RR pointer=0. Lock cleared. err_o=0. rtrn_vld_o=0. rtrn_data_o/rtrn_tid_o=0. ack_o=0. mem_req_o=0. outstanding_o=0. busy_o=0.
- States: IDLE / LOCKED.
  - IDLE: if !stall_i, a free entry exists and any req_i is high, select a port (RR: first requester at or after pointer; FixedPrio: lowest index). Allocate the lowest-index free entry. Drive mem_req_o=1 combinationally that cycle.
  - Request held by mem_ack_i=0: move to LOCKED.
  - LOCKED: selected port and entry index are frozen. mem_req_o stays 1 and stall_i is ignored until mem_ack_i, then return to IDLE.
- Accept cycle (mem_req_o & mem_ack_i):
  - ack_o[sel]=1 for exactly that cycle.
  - Table entry is set valid and stores {port, req_tid}.
  - RR pointer moves to sel+1 mod NumPorts.
  - Zero-latency accept is allowed (IDLE grant and ack in the same cycle).
- Client rule: req_i and payload are held until ack_o. The block does not check this.
- Table full (outstanding_o==MaxTx): no new grant and mem_req_o=0. An already LOCKED request proceeds.
- Return path (latency 1):
  - On mem_rtrn_vld_i with the entry valid, the next cycle drives rtrn_vld_o[entry.port]=1, rtrn_tid_o=entry.tid and rtrn_data_o=registered data.
  - The entry is invalidated at that same clock edge.
- Return to an invalid entry: no rtrn_vld_o; err_o set and held until reset.
- Simultaneous free and allocate in one cycle:
  - The entry being freed is not eligible for allocation that cycle.
  - outstanding_o = old + alloc - free, and never wraps.
- Back-to-back returns are supported every cycle, with no return backpressure.
- A client may accept returns for multiple IDs in any order. Ordering follows the adapter.
- NumPorts=1: the arbiter degenerates to a pass-through with ID remap. The RR pointer is constant 0.
- Reset mid-operation: all in-flight state is discarded. Late returns after reset set err_o.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately. After release with no stimulus, busy_o=0 and err_o=0.
- RR fairness: NumPorts=2, both req_i high continuously, mem_ack_i=1 always -> grants alternate 0,1,0,1. mem_tid_o=0,1,2,3. outstanding_o counts 1..4.
- ID remap/return: port1 tid=3 granted as mem_tid 0; mem_rtrn_vld_i with tid 0, data 0xABCD -> next cycle rtrn_vld_o=2'b10, rtrn_tid_o=3, rtrn_data_o=0xABCD, outstanding_o drops by 1.
- Full and free-same-cycle: fill MaxTx=8 entries -> mem_req_o=0 while req_i is high. Return tid 5 in the same cycle a request is pending -> the next grant uses entry 5, one cycle later.
- Handshake hold: mem_ack_i=0 for 3 cycles with stall_i rising in cycle 2 -> mem_req_o, mem_data_o and mem_tid_o stable. ack_o pulses only in the ack cycle.
- Error: mem_rtrn_vld_i with tid 7 unallocated -> rtrn_vld_o=0, err_o=1 sticky until rst_i. FixedPrio=1 with both ports requesting -> port 0 always wins.
